// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ valid/ready writers into one FIFO write port.
// It registers the write and tracks the FIFO's acknowledge and overflow responses.
module fifo_wr_arbiter #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int NUM_REQ    = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]           fifo_data_in,
    input  logic                            fifo_full,
    input  logic                            fifo_almostfull,
    input  logic                            fifo_wr_ack,
    input  logic                            fifo_overflow,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic [15:0]                     wr_count,
    output logic                            err_overflow,
    output logic                            err_noack
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = IDW + 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || FIFO_DEPTH < 2) begin : g_bad_param
        $error("fifo_wr_arbiter: NUM_REQ must be 2..8 and FIFO_DEPTH at least 2");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_STALL} state_t;

    state_t                  state_q, state_d;
    logic [IDW-1:0]          rr_ptr_q, rr_ptr_d;
    logic                    wr_en_q;
    logic [FIFO_WIDTH-1:0]   data_q;
    logic [IDW-1:0]          grant_q;
    logic [15:0]             cnt_q;
    logic                    ack_pend_q;
    logic                    err_ovf_q;
    logic                    err_noack_q;

    logic [FIFO_WIDTH-1:0]   data_arr [NUM_REQ];
    logic [IDW-1:0]          win_idx;
    logic                    win_found;
    logic [CW-1:0]           cand;
    logic                    any_valid;
    logic                    can_issue;
    logic                    xfer;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign data_arr[gi] = req_data[gi*FIFO_WIDTH +: FIFO_WIDTH];
    end

    assign any_valid = |req_valid;
    // A write already in flight will consume the last free slot, so hold off.
    assign can_issue = !fifo_full && !(fifo_almostfull && wr_en_q);

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr_q} + CW'(k);
            if (cand >= CW'(NUM_REQ)) begin
                cand = cand - CW'(NUM_REQ);
            end
            if (req_valid[cand[IDW-1:0]]) begin
                win_idx   = cand[IDW-1:0];
                win_found = 1'b1;
            end
        end
    end

    assign rr_ptr_d = (win_idx == IDW'(NUM_REQ - 1)) ? '0 : win_idx + IDW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_WRITE: begin
                if (xfer) begin
                    state_d = ST_WRITE;
                end else if (any_valid) begin
                    state_d = ST_STALL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STALL: begin
                if (xfer) begin
                    state_d = ST_WRITE;
                end else if (!any_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        xfer      = 1'b0;
        if (!rst && can_issue && win_found) begin
            req_ready[win_idx] = 1'b1;
            xfer               = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            wr_en_q     <= 1'b0;
            data_q      <= '0;
            grant_q     <= '0;
            cnt_q       <= '0;
            ack_pend_q  <= 1'b0;
            err_ovf_q   <= 1'b0;
            err_noack_q <= 1'b0;
        end else begin
            wr_en_q    <= xfer;
            ack_pend_q <= wr_en_q;
            if (xfer) begin
                data_q   <= data_arr[win_idx];
                grant_q  <= win_idx;
                rr_ptr_q <= rr_ptr_d;
                cnt_q    <= cnt_q + 16'd1;
            end
            if (fifo_overflow) begin
                err_ovf_q <= 1'b1;
            end
            // A write whose response slot shows neither ack nor overflow went missing.
            if (ack_pend_q && !fifo_wr_ack && !fifo_overflow) begin
                err_noack_q <= 1'b1;
            end
        end
    end

    assign fifo_wr_en   = wr_en_q;
    assign fifo_data_in = data_q;
    assign grant_id     = grant_q;
    assign wr_count     = cnt_q;
    assign err_overflow = err_ovf_q;
    assign err_noack    = err_noack_q;
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter FIFO_WIDTH, default 16, data word width.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, depth of the downstream FIFO.
REQ-003 The block SHALL have parameter NUM_REQ, default 4, number of writers (2..8).
REQ-004 clk  in  1  single clock, all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 req_valid  in  NUM_REQ  per-writer request; bit i belongs to writer i.
REQ-007 req_data  in  NUM_REQ*FIFO_WIDTH  writer i data in slice [i*FIFO_WIDTH +: FIFO_WIDTH].
REQ-008 req_ready  out  NUM_REQ  combinational accept; transfer when valid & ready at a rising edge.
REQ-009 fifo_wr_en  out  1  registered FIFO write enable.
REQ-010 fifo_data_in  out  FIFO_WIDTH  registered FIFO write data.
REQ-011 fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow  in  1 each  FIFO status.
REQ-012 grant_id  out  $clog2(NUM_REQ)  registered index of the writer behind the current fifo_wr_en.
REQ-013 wr_count  out  16  registered count of accepted words, wraps at 2^16.
REQ-014 err_overflow, err_noack  out  1 each  sticky error flags.

Function
REQ-015 Arbitration SHALL be round-robin: winner is the first i with req_valid[i]=1 searching from rr_ptr upward, modulo NUM_REQ.
REQ-016 can_issue SHALL be !fifo_full & !(fifo_almostfull & fifo_wr_en); the second term blocks a back-to-back write that would overrun the FIFO's last free slot.
REQ-017 req_ready SHALL be one-hot at the winner when can_issue=1 and any req_valid=1, else all zero; never more than one bit set.
REQ-018 On a transfer, the next edge SHALL set fifo_wr_en=1, fifo_data_in=winner data, grant_id=winner, rr_ptr=(winner+1) mod NUM_REQ, wr_count+1; latency valid&ready to fifo_wr_en is 1 cycle.
REQ-019 Without a transfer, fifo_wr_en SHALL be 0 the next cycle, and fifo_data_in, grant_id and rr_ptr SHALL hold.
REQ-020 Throughput SHALL be one word per cycle while can_issue stays 1.
REQ-021 FSM states SHALL be IDLE, WRITE and STALL.
REQ-022 IDLE: no request; a transfer goes to WRITE; valid with !can_issue goes to STALL.
REQ-023 WRITE: a transfer stays in WRITE; valid with !can_issue goes to STALL; no valid goes to IDLE.
REQ-024 STALL: req_ready is all zero; when can_issue returns with valid, the FSM transfers and goes to WRITE; when valid drops, it goes to IDLE.
REQ-025 A writer that drops valid before ready loses its turn; no data SHALL be taken from it.
REQ-026 ack_pend SHALL equal fifo_wr_en delayed one cycle.
REQ-027 At an edge where ack_pend=1, fifo_wr_ack=0 and fifo_overflow=0, err_noack SHALL set.
REQ-028 At any edge with fifo_overflow=1, err_overflow SHALL set.
REQ-029 Both error flags SHALL clear only on rst.

Reset
REQ-030 rst=1 at an edge SHALL force state=IDLE, rr_ptr=0, fifo_wr_en=0, fifo_data_in=0, grant_id=0, wr_count=0, ack_pend=0, err_overflow=0, err_noack=0.
REQ-031 While rst=1, req_ready SHALL be all zero.
REQ-032 A reset mid-operation SHALL drop any pending write; the word on fifo_data_in is not retried.

Verification
REQ-033 All four writers hold valid with data 0xA0+i and the FIFO drains each cycle -> writes in order 0,1,2,3,0; one per cycle; wr_count=5 after 5 transfers.
REQ-034 The FIFO fills with 7 words and writes continue -> the 8th write issues; the next cycle is STALL with req_ready=0 and no 9th write; err_overflow stays 0.
REQ-035 Only writer 2 valid, with rr_ptr=3 -> writer 2 is granted and rr_ptr becomes 3.
REQ-036 fifo_wr_ack is forced low after a write -> err_noack=1 and stays 1 until rst.
REQ-037 rst asserts during a WRITE burst -> next cycle fifo_wr_en=0 and wr_count=0; after release, arbitration starts from writer 0.
REQ-038 fifo_overflow is injected high for one cycle -> err_overflow=1, sticky.
